// File: rtl/bp_direction_unit.sv
// Branch direction unit: 2-bit saturating counter table, prediction tracking
// through ID/EX, misprediction detection and resolved-branch statistics.
module bp_direction_unit #(
    parameter int BHT_ADDR_LEN = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCRead,
    input  logic        BTBHit,
    input  logic [31:0] BTBTarget,
    input  logic        Stall,
    input  logic        ExValid,
    input  logic        ExIsBranch,
    input  logic        ExTaken,
    input  logic [31:0] ExPC,
    input  logic [31:0] ExTarget,
    output logic        PredTaken,
    output logic [31:0] NPC,
    output logic        BTBWrite,
    output logic [31:0] PCWrite,
    output logic [31:0] PCWritePredict,
    output logic        Mispredict,
    output logic [31:0] CorrectPC,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredCount
);
    localparam int unsigned BHT_SIZE = 2 ** BHT_ADDR_LEN;

    logic [1:0]              bht [BHT_SIZE];
    logic [BHT_ADDR_LEN-1:0] rd_idx;
    logic [BHT_ADDR_LEN-1:0] wr_idx;

    logic        id_valid;
    logic        id_pred;
    logic [31:0] id_target;
    logic        ex_valid;
    logic        ex_pred;
    logic [31:0] ex_target;

    logic        tracked_pred;
    logic        resolve;

    assign rd_idx  = PCRead[BHT_ADDR_LEN+1:2];
    assign wr_idx  = ExPC[BHT_ADDR_LEN+1:2];
    assign resolve = ExValid & ExIsBranch;

    always_comb begin
        PredTaken      = BTBHit & bht[rd_idx][1];
        NPC            = PredTaken ? BTBTarget : PCRead + 32'd4;
        tracked_pred   = ex_valid & ex_pred;
        Mispredict     = ExValid & ((ExIsBranch & (ExTaken != tracked_pred))
                       | (ExIsBranch & ExTaken & tracked_pred & (ExTarget != ex_target))
                       | (~ExIsBranch & tracked_pred));
        CorrectPC      = (ExIsBranch & ExTaken) ? ExTarget : ExPC + 32'd4;
        BTBWrite       = ExValid & ExIsBranch & ExTaken;
        PCWrite        = ExPC;
        PCWritePredict = ExTarget;
    end

    // Counter write happens at the edge, so a same-cycle read sees the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < BHT_SIZE; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (resolve) begin
            if (ExTaken) begin
                if (bht[wr_idx] != 2'b11) bht[wr_idx] <= bht[wr_idx] + 2'd1;
            end else begin
                if (bht[wr_idx] != 2'b00) bht[wr_idx] <= bht[wr_idx] - 2'd1;
            end
        end
    end

    // A flush clears both valids even when stalled; payload follows Stall as usual.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid  <= 1'b0;
            id_pred   <= 1'b0;
            id_target <= '0;
            ex_valid  <= 1'b0;
            ex_pred   <= 1'b0;
            ex_target <= '0;
        end else begin
            if (!Stall) begin
                id_pred   <= PredTaken;
                id_target <= NPC;
                ex_pred   <= id_pred;
                ex_target <= id_target;
            end
            if (Mispredict) begin
                id_valid <= 1'b0;
                ex_valid <= 1'b0;
            end else if (!Stall) begin
                id_valid <= 1'b1;
                ex_valid <= id_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            BranchCount  <= '0;
            MispredCount <= '0;
        end else begin
            if (resolve)    BranchCount  <= BranchCount + 32'd1;
            if (Mispredict) MispredCount <= MispredCount + 32'd1;
        end
    end

endmodule

// File: doc/bp_direction_unit.md
BP_DIRECTION_UNIT -- requirements
Module: bp_direction_unit

Interface
REQ-001 Parameter BHT_ADDR_LEN, default 12; counter table index width; table holds 2^BHT_ADDR_LEN two-bit counters.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 PCRead  in  32  fetch-stage PC.
REQ-005 BTBHit  in  1  target-buffer hit for PCRead.
REQ-006 BTBTarget  in  32  target-buffer predicted target for PCRead.
REQ-007 Stall  in  1  freeze fetch/decode tracking.
REQ-008 ExValid  in  1  execute stage holds a valid instruction.
REQ-009 ExIsBranch  in  1  execute instruction is a conditional branch.
REQ-010 ExTaken  in  1  resolved branch direction.
REQ-011 ExPC  in  32  execute instruction PC.
REQ-012 ExTarget  in  32  resolved branch target.
REQ-013 PredTaken  out  1  fetch-stage taken prediction.
REQ-014 NPC  out  32  predicted next fetch PC.
REQ-015 BTBWrite  out  1  target-buffer write request.
REQ-016 PCWrite  out  32  target-buffer write key.
REQ-017 PCWritePredict  out  32  target-buffer write target.
REQ-018 Mispredict  out  1  flush request to pipeline.
REQ-019 CorrectPC  out  32  redirect PC, valid when Mispredict=1.
REQ-020 BranchCount, MispredCount  out  32 each  resolved-branch and misprediction statistics.

Function
REQ-021 Read index = PCRead[BHT_ADDR_LEN+1:2]; PredTaken = BTBHit AND counter[index][1]; NPC = PredTaken ? BTBTarget : PCRead+4; combinational, no added latency.
REQ-022 Counter update when ExValid&ExIsBranch, index ExPC[BHT_ADDR_LEN+1:2]: taken -> increment saturating at 3; not taken -> decrement saturating at 0; written at rising edge.
REQ-023 Same-index read and update in one cycle: read returns pre-update value.
REQ-024 Tracking pipe, two stages (ID, EX), each {valid, predTaken, predTarget}: when Stall=0, ID <= {1, PredTaken, NPC} and EX <= ID; Stall=1 holds both.
REQ-025 Mispredict = ExValid & ( (ExIsBranch & (ExTaken != tracked predTaken)) | (ExIsBranch & ExTaken & tracked predTaken & ExTarget != tracked predTarget) | (!ExIsBranch & tracked predTaken) ); tracked predTaken treated as 0 when EX.valid=0.
REQ-026 CorrectPC = (ExIsBranch & ExTaken) ? ExTarget : ExPC+4.
REQ-027 Mispredict=1 clears valid in both tracking stages at the next edge, overriding Stall.
REQ-028 BTBWrite = ExValid & ExIsBranch & ExTaken, combinational; PCWrite = ExPC; PCWritePredict = ExTarget.
REQ-029 BranchCount increments per cycle with ExValid&ExIsBranch; MispredCount increments per cycle with Mispredict; both wrap modulo 2^32.
REQ-030 PC+4 arithmetic is 32-bit, wraps from 0xFFFFFFFC to 0x00000000.

Reset
REQ-031 rst=0 asynchronously sets all counters to 2'b01, both tracking valids to 0, predTaken/predTarget to 0, BranchCount and MispredCount to 0.
REQ-032 During reset, outputs follow REQ-021/025/028 from reset state; with ExValid=0, Mispredict=0 and BTBWrite=0.
REQ-033 Reset mid-operation discards all tracked predictions; no counter update occurs while rst=0.

Verification
REQ-034 Reset, PCRead=0x100, BTBHit=1, BTBTarget=0x200 -> PredTaken=0, NPC=0x104.
REQ-035 Resolve ExPC=0x100 taken, ExTarget=0x200, once -> BTBWrite=1, PCWrite=0x100, PCWritePredict=0x200; next cycle PCRead=0x100, BTBHit=1 -> PredTaken=1, NPC=0x200.
REQ-036 Counter at 3, five not-taken resolutions -> values 2,1,0,0,0; four taken -> 1,2,3,3.
REQ-037 Fetch 0x100 predicted taken to 0x200, two unstalled cycles, ExValid=1, ExIsBranch=1, ExTaken=0, ExPC=0x100 -> Mispredict=1, CorrectPC=0x104, MispredCount=1, both tracking valids 0 next cycle.
REQ-038 Stall=1 for 3 cycles between fetch and execute of a predicted-taken branch, then resolve taken to matching target -> Mispredict=0, BranchCount=1.
REQ-039 Predicted-taken non-branch (ExIsBranch=0, ExPC=0x300) -> Mispredict=1, CorrectPC=0x304, BTBWrite=0.
